// File: rtl/bram_rd_sched.sv
// Round-robin scheduler sharing one BRAM read port between two burst requesters.
// Returned words leave as a tagged stream (channel id + last marker), no backpressure.
module bram_rd_sched #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    output logic [1:0]        ack,
    output logic [1:0]        done,
    output logic              busy,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tid,
    output logic              m_tlast
);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain, StDone0} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, len_q;
    logic [ADDR_W:0]   idx_q;
    logic              id_q;
    logic              rr_q;

    logic [RD_LAT-1:0] pv_q, pid_q, plast_q;

    logic              gnt;
    logic [ADDR_W-1:0] gnt_base, gnt_len;
    logic              grant;
    logic              last_rd;
    logic              beat_last;

    // Tie goes to the channel that was not granted last.
    always_comb begin
        gnt = (req == 2'b11) ? ~rr_q : req[1];
        gnt_base = gnt ? base1 : base0;
        gnt_len  = gnt ? len1 : len0;
    end

    assign grant     = (state_q == StIdle) && (|req);
    assign last_rd   = (idx_q + (ADDR_W+1)'(1)) == {1'b0, len_q};
    assign beat_last = pv_q[RD_LAT-1] && plast_q[RD_LAT-1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant) begin
                base_q <= gnt_base;
                len_q  <= gnt_len;
                idx_q  <= '0;
                id_q   <= gnt;
                rr_q   <= gnt;
            end else if (state_q == StBurst) begin
                idx_q <= idx_q + (ADDR_W+1)'(1);
            end
        end
    end

    // Read-valid pipeline aligned with BRAM latency: {enb, id, last}.
    logic [RD_LAT:0] pv_ext, pid_ext, plast_ext;
    assign pv_ext    = {pv_q, bram_enb};
    assign pid_ext   = {pid_q, id_q};
    assign plast_ext = {plast_q, bram_enb && last_rd};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q    <= '0;
            pid_q   <= '0;
            plast_q <= '0;
        end else begin
            pv_q    <= pv_ext[RD_LAT-1:0];
            pid_q   <= pid_ext[RD_LAT-1:0];
            plast_q <= plast_ext[RD_LAT-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|req) state_d = (gnt_len == '0) ? StDone0 : StBurst;
            end
            StBurst: begin
                if (last_rd) state_d = StDrain;
            end
            StDrain: begin
                if (beat_last) state_d = StIdle;
            end
            StDone0: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; ack is gated so it stays low while reset is held.
    always_comb begin
        ack        = 2'b00;
        done       = 2'b00;
        bram_enb   = 1'b0;
        bram_addrb = '0;
        if (grant && rst_n) ack = gnt ? 2'b10 : 2'b01;
        if (state_q == StBurst) begin
            bram_enb   = 1'b1;
            bram_addrb = base_q + idx_q[ADDR_W-1:0];
        end
        if ((state_q == StDrain && beat_last) || state_q == StDone0) begin
            done = id_q ? 2'b10 : 2'b01;
        end
    end

    assign busy     = (state_q != StIdle);
    assign m_tdata  = bram_doutb;
    assign m_tvalid = pv_q[RD_LAT-1];
    assign m_tid    = pid_q[RD_LAT-1];
    assign m_tlast  = plast_q[RD_LAT-1];

endmodule

// File: tb/tb_bram_rd_sched.sv
// Directed bench for bram_rd_sched with a 2-cycle BRAM model returning a tag of the address.
module tb_bram_rd_sched;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [13:0] base0, base1, len0, len1;
    logic [1:0]  ack, done;
    logic        busy, bram_enb;
    logic [13:0] bram_addrb;
    logic [63:0] bram_doutb, m_tdata;
    logic        m_tvalid, m_tid, m_tlast;

    int checks = 0;
    int failures = 0;

    bram_rd_sched #(.ADDR_W(14), .DATA_W(64), .RD_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .base0     (base0),
        .base1     (base1),
        .len0      (len0),
        .len1      (len1),
        .ack       (ack),
        .done      (done),
        .busy      (busy),
        .bram_enb  (bram_enb),
        .bram_addrb(bram_addrb),
        .bram_doutb(bram_doutb),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tid     (m_tid),
        .m_tlast   (m_tlast)
    );

    always #5 clk = ~clk;

    // BRAM model: data word tags the address that was read, LAT cycles later.
    logic [63:0] d1, d2;
    always @(posedge clk) begin
        d1 <= {48'hDA7A_0000_0000, 2'b00, bram_addrb};
        d2 <= d1;
    end
    assign bram_doutb = d2;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int ch, input logic [13:0] b, input int l);
        if (ch == 0) begin
            base0 = b;
            len0  = 14'(l);
        end else begin
            base1 = b;
            len1  = 14'(l);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_enb"}, 64'(bram_enb), 64'(0));
        chk({tag, "_addr"}, 64'(bram_addrb), 64'(0));
        chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
        chk({tag, "_tid"}, 64'(m_tid), 64'(0));
        chk({tag, "_tlast"}, 64'(m_tlast), 64'(0));
    endtask

    // Called in the grant cycle T; returns in cycle T+l+LAT+1 (or T+2 for l=0).
    task automatic run_burst(input int ch, input logic [13:0] b, input int l, input bit drop,
                             input logic [13:0] nb, input int nl);
        logic [13:0] a;
        bit          e_enb, e_v;
        set_ch(ch, b, l);
        #1;
        chk("ack_T", 64'(ack), 64'(2'b01 << ch));
        chk("busy_T", 64'(busy), 64'(0));
        tick();
        if (drop) req[ch] = 1'b0;
        set_ch(ch, nb, nl);
        #1;
        if (l == 0) begin
            chk("z_done", 64'(done), 64'(2'b01 << ch));
            chk("z_enb", 64'(bram_enb), 64'(0));
            chk("z_tvalid", 64'(m_tvalid), 64'(0));
            chk("z_busy", 64'(busy), 64'(1));
            tick();
        end else begin
            for (int k = 1; k <= l + LAT; k++) begin
                e_enb = (k <= l);
                e_v   = (k > LAT);
                a     = b + 14'(k - 1);
                chk("enb", 64'(bram_enb), 64'(e_enb));
                chk("addr", 64'(bram_addrb), e_enb ? 64'(a) : 64'(0));
                chk("busy", 64'(busy), 64'(1));
                chk("ack_in_burst", 64'(ack), 64'(0));
                chk("tvalid", 64'(m_tvalid), 64'(e_v));
                chk("tlast", 64'(m_tlast), 64'(k == l + LAT));
                chk("done", 64'(done), (k == l + LAT) ? 64'(2'b01 << ch) : 64'(0));
                if (e_v) begin
                    a = b + 14'(k - LAT - 1);
                    chk("tid", 64'(m_tid), 64'(ch));
                    chk("tdata", m_tdata, {48'hDA7A_0000_0000, 2'b00, a});
                end
                tick();
            end
        end
        chk("end_busy", 64'(busy), 64'(0));
        chk("end_done", 64'(done), 64'(0));
        chk("end_enb", 64'(bram_enb), 64'(0));
        chk("end_tvalid", 64'(m_tvalid), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b11;
        set_ch(0, 14'h0100, 3);
        set_ch(1, 14'h0200, 3);
        tick();
        tick();
        chk_idle_outputs("reset");

        // Contention held from reset: ch0, ch1, ch0 with gaps between bursts.
        rst_n = 1'b1;
        run_burst(0, 14'h0100, 3, 1'b0, 14'h0100, 3);
        run_burst(1, 14'h0200, 3, 1'b0, 14'h0200, 3);
        req[1] = 1'b0;
        run_burst(0, 14'h0100, 3, 1'b1, 14'h0100, 3);
        chk("idle_no_ack", 64'(ack), 64'(0));

        // Single burst.
        req = 2'b01;
        run_burst(0, 14'h0010, 4, 1'b1, 14'h0010, 4);

        // Zero length on ch1.
        req = 2'b10;
        run_burst(1, 14'h0000, 0, 1'b1, 14'h0000, 0);

        // Address wrap-around.
        req = 2'b01;
        run_burst(0, 14'h3FFC, 8, 1'b1, 14'h3FFC, 8);

        // Inputs change after ack; req stays high and is granted again.
        req = 2'b01;
        run_burst(0, 14'h0040, 3, 1'b0, 14'h0100, 2);
        run_burst(0, 14'h0100, 2, 1'b1, 14'h0100, 2);

        // Reset in the middle of a len=10 burst.
        req = 2'b01;
        set_ch(0, 14'h0000, 10);
        #1;
        chk("mr_ack", 64'(ack), 64'(2'b01));
        tick();
        req = 2'b00;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("mid_reset");
        tick();
        chk("mr_done2", 64'(done), 64'(0));
        chk("mr_tvalid2", 64'(m_tvalid), 64'(0));
        req = 2'b11;
        set_ch(1, 14'h0200, 2);
        rst_n = 1'b1;
        run_burst(0, 14'h0020, 2, 1'b1, 14'h0020, 2);
        run_burst(1, 14'h0200, 2, 1'b1, 14'h0200, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_rd_sched.md
# bram_rd_sched

Scheduler that shares one BRAM read port between two stream requesters, for example the feature-map and weight loaders of an accelerator stage. Each requester asks for a burst given as base address plus length. The block grants bursts round-robin and issues one BRAM read per cycle. It emits the returned words as a tagged AXI-Stream-style output with no backpressure, carrying channel id and last-beat marker.

## Interface
- ADDR_W, 14, BRAM address width; also the width of base and length.
- DATA_W, 64, BRAM/stream data width.
- RD_LAT, 2, cycles from bram_enb to valid bram_doutb (1..4).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  2  per-channel burst request, level; held until matching ack.
- base0, base1  in  ADDR_W  burst start address, sampled at grant.
- len0, len1  in  ADDR_W  burst length in words (0..2^ADDR_W-1), sampled at grant.
- ack  out  2  one-cycle pulse: request accepted, base/len latched.
- done  out  2  one-cycle pulse: burst fully delivered.
- busy  out  1  high from grant until the done cycle inclusive.
- bram_enb  out  1  BRAM read enable.
- bram_addrb  out  ADDR_W  BRAM read address.
- bram_doutb  in  DATA_W  BRAM read data.
- m_tdata  out  DATA_W  stream data; combinational copy of bram_doutb.
- m_tvalid  out  1  stream beat valid.
- m_tid  out  1  channel of current beat.
- m_tlast  out  1  last beat of burst.

## Operation
- FSM states:
  - IDLE: arbitrate. If any req is high, pulse ack[g] for the winner g, latch base/len/id, then go to BURST. If the latched len is 0, go to DONE0 instead.
  - BURST: bram_enb=1 and bram_addrb=base+idx for idx=0..len-1. After issuing the last read, go to DRAIN.
  - DRAIN: wait until the last beat exits the pipeline, pulse done[id], return to IDLE.
  - DONE0: pulse done[id] with no reads and no stream beats, return to IDLE.
- Arbitration is round-robin. A pointer holds the last granted channel. If both channels request, the non-last channel wins. The pointer resets so that ch0 wins the first tie.
- Address arithmetic is modulo 2^ADDR_W: base+idx wraps to 0 with no error. The index counter is ADDR_W+1 bits so the len comparison never overflows.
- Valid pipeline: an RD_LAT-deep shift register carries {enb, id, last}.
  - m_tvalid, m_tid and m_tlast come from the final stage.
  - last is set on the read with idx=len-1.
- req is ignored outside IDLE. A req still high after done is a new request.
- base/len changes after ack have no effect on the current burst.

## Timing
- Reset values: ack=0, done=0, busy=0, bram_enb=0, bram_addrb=0, m_tvalid=0, m_tid=0, m_tlast=0. The pipeline is cleared and the RR pointer is set to ch1, so ch0 wins the first tie.
- Grant at cycle T (IDLE with req seen): ack high in T; busy high from T+1.
- Read issue: first bram_enb in T+1; reads issue on consecutive cycles T+1..T+len with no gaps.
- Stream beats: first m_tvalid in T+1+RD_LAT; last beat (m_tlast=1) in T+len+RD_LAT.
- Completion: done[id] pulses in the same cycle as the last beat. busy falls and state returns to IDLE at T+len+RD_LAT+1. The next grant can occur in that cycle.
- Inter-burst gap: minimum RD_LAT+1 idle bram_enb cycles between bursts, so beats from two bursts never interleave.
- len=0: ack in T, done in T+1, IDLE in T+2. No bram_enb and no m_tvalid.
- Reset mid-burst: all outputs return to reset values on the next edge. In-flight beats are discarded and no done is issued.

## Test plan
- Single burst: req=01, base0=0x0010, len0=4, RD_LAT=2.
  - ack=01 at T; enb T+1..T+4 with addresses 0x10..0x13.
  - tvalid T+3..T+6, tid=0; tlast and done=01 at T+6.
- Contention: req=11 held from reset with both len=3.
  - Grants come in order ch0, ch1, ch0.
  - tid sequence is 0,0,0 then 1,1,1, with a 3-cycle enb gap between bursts.
- Zero length: req=10, len1=0.
  - ack=10 at T, done=10 at T+1; enb and tvalid stay 0 throughout.
- Wrap-around: base0=0x3FFC, len0=8.
  - Addresses 0x3FFC..0x3FFF, then 0x0000..0x0003.
  - 8 beats, tlast on the 8th.
- Input stability: change base0/len0 one cycle after ack.
  - The burst uses the latched values.
  - req left high after done produces a second ack in the IDLE cycle.
- Reset mid-burst: rst_n=0 at T+3 of a len=10 burst.
  - All outputs are 0 the next cycle and no done is issued.
  - A fresh req after reset is granted to ch0 first on a tie.
